// File: rtl/udp_payload_fifo.sv
// Packet-aware UDP payload receive buffer: stores datagrams speculatively and only
// releases complete ones. Optional statistics counters enabled by UDP_FIFO_STATS_EN.
module udp_payload_fifo #(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  payload,
  input  logic        payload_valid,
  input  logic        payload_last,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] drop_count,
  output logic [15:0] pkt_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DISCARD
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_commit_ptr;
  logic [PW-1:0]   r_rd_ptr;

  logic [8:0]      r_mem [0:DEPTH-1];
  logic [8:0]      r_ram_q;
  logic            r_ram_vld;

  logic [7:0]      r_out_data;
  logic            r_out_last;
  logic            r_out_valid;

  logic [PW-1:0]   w_occ;
  logic            w_full;
  logic            w_can_write;
  logic            w_wr_en;
  logic            w_overflow;
  logic            w_commit;
  logic            w_drop;
  logic            w_move;
  logic            w_rd_en;

  // Fullness uses the current rd_ptr, so a same-cycle read frees nothing yet.
  assign w_occ       = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_occ == FULL_OCC);
  assign w_can_write = payload_valid && (r_state != ST_DISCARD);
  assign w_wr_en     = w_can_write && !w_full;
  assign w_overflow  = w_can_write && w_full;
  assign w_commit    = w_wr_en && payload_last;
  assign w_drop      = payload_valid && payload_last &&
                       ((r_state == ST_DISCARD) || w_full);

  // Two-entry output pipeline: RAM read register feeding the output register.
  assign w_move  = r_ram_vld && (!r_out_valid || m_ready);
  assign w_rd_en = (r_rd_ptr != r_commit_ptr) && (!r_ram_vld || w_move);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= {payload_last, payload};
    end
    if (w_rd_en) begin
      r_ram_q <= r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_WRITE: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_commit) begin
              r_commit_ptr <= r_wr_ptr + PW'(1);
              r_state      <= ST_IDLE;
            end else begin
              r_state      <= ST_WRITE;
            end
          end else if (w_overflow) begin
            // Rewind discards every byte of the datagram written so far.
            r_wr_ptr <= r_commit_ptr;
            r_state  <= w_drop ? ST_IDLE : ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (w_drop) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr    <= '0;
      r_ram_vld   <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_rd_en) begin
        r_ram_vld <= 1'b1;
      end else if (w_move) begin
        r_ram_vld <= 1'b0;
      end
      if (w_move) begin
        r_out_data  <= r_ram_q[7:0];
        r_out_last  <= r_ram_q[8];
        r_out_valid <= 1'b1;
      end else if (m_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_data  = r_out_data;
  assign m_last  = r_out_last;
  assign m_valid = r_out_valid;

`ifdef UDP_FIFO_STATS_EN
  logic [15:0] r_drop_cnt;
  logic [15:0] r_pkt_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_drop_cnt <= 16'h0000;
      r_pkt_cnt  <= 16'h0000;
    end else begin
      if (w_commit) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign drop_count = r_drop_cnt;
  assign pkt_count  = r_pkt_cnt;
`else
  assign drop_count = 16'h0000;
  assign pkt_count  = 16'h0000;
`endif

endmodule
